// File: rtl/regfile_wb_pkg.sv
// Shared constants and types for the register-file write-back controller.
// The write-back entry carries a destination register and its result.
package regfile_wb_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 32;

    // One pending register-file write.
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

    // One-hot mask for a register address, used by the busy scoreboard.
    function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [ADDR_W-1:0] a);
        logic [NUM_REGS-1:0] mask;
        mask = '0;
        mask[a] = 1'b1;
        return mask;
    endfunction

endpackage

// File: rtl/regfile_writeback_fifo.sv
// wb_fifo: small synchronous FIFO of write-back entries shared by the load
// and mul/div sources. DEPTH must be a power of two (pointers wrap freely).
// A push while full or a pop while empty is ignored.
module wb_fifo
    import regfile_wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  wb_entry_t                din,
    input  logic                     pop,
    output wb_entry_t                dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    wb_entry_t         mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [CW-1:0]     count_q;
    logic              do_push;
    logic              do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];
    assign count   = count_q;

    // Pointer and occupancy bookkeeping; reset empties the queue.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/regfile_writeback.sv
// regfile_writeback: merges ALU, load and mul/div results into one registered
// register-file write per cycle and maintains the RAW busy scoreboard.
// Optional forwarding ports are compiled in with REGFILE_WB_BYPASS_EN.
//
// Handshake: a load (mul/div) result is taken on a posedge where
// ld_valid && ld_ready (md_valid && md_ready) are both high; valid may be
// raised at any time and must hold its payload until taken. Readiness
// depends only on registered FIFO occupancy and ld_valid. ALU results have
// no ready and are always taken.
module regfile_writeback
#(
    parameter int DATA_W = regfile_wb_pkg::DATA_W,
    parameter int ADDR_W = regfile_wb_pkg::ADDR_W,
    parameter int QDEPTH = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      alu_valid,
    input  logic [ADDR_W-1:0]         alu_addr,
    input  logic [DATA_W-1:0]         alu_data,
    input  logic                      ld_valid,
    output logic                      ld_ready,
    input  logic [ADDR_W-1:0]         ld_addr,
    input  logic [DATA_W-1:0]         ld_data,
    input  logic                      md_valid,
    output logic                      md_ready,
    input  logic [ADDR_W-1:0]         md_addr,
    input  logic [DATA_W-1:0]         md_data,
    input  logic                      rsv_valid,
    input  logic [ADDR_W-1:0]         rsv_addr,
    output logic                      rf_write,
    output logic [ADDR_W-1:0]         rf_addr,
    output logic [DATA_W-1:0]         rf_data,
    output logic [31:0]               busy,
    output logic [$clog2(QDEPTH):0]   q_count
`ifdef REGFILE_WB_BYPASS_EN
    ,
    input  logic [ADDR_W-1:0]         byp_s_addr,
    input  logic [ADDR_W-1:0]         byp_t_addr,
    output logic                      byp_s_hit,
    output logic                      byp_t_hit,
    output logic [DATA_W-1:0]         byp_s_data,
    output logic [DATA_W-1:0]         byp_t_data
`endif
);

    import regfile_wb_pkg::*;

    localparam int QCW = $clog2(QDEPTH) + 1;

    // ---------------------------------------------------------------
    // Enqueue arbitration: at most one entry per cycle, load first.
    // ---------------------------------------------------------------
    logic              room;
    logic              ld_push;
    logic              md_push;
    logic              q_push;
    wb_entry_t         q_din;
    wb_entry_t         q_head;
    logic              q_pop;
    logic              q_empty;
    logic              q_full;
    logic [QCW-1:0]    q_cnt;

    // A full FIFO refuses new entries even when it pops on the same edge.
    assign room     = (q_cnt < QCW'(QDEPTH));
    assign ld_ready = room;
    assign md_ready = room && !ld_valid;
    assign ld_push  = ld_valid && ld_ready;
    assign md_push  = md_valid && md_ready;
    assign q_push   = ld_push || md_push;
    assign q_count  = q_cnt;

    // Payload mux for the single enqueue slot.
    always_comb begin
        q_din = '0;
        if (ld_push) begin
            q_din.addr = ld_addr;
            q_din.data = ld_data;
        end else begin
            q_din.addr = md_addr;
            q_din.data = md_data;
        end
    end

    wb_fifo #(
        .DEPTH (QDEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (q_push),
        .din   (q_din),
        .pop   (q_pop),
        .dout  (q_head),
        .count (q_cnt),
        .empty (q_empty),
        .full  (q_full)
    );

    // ---------------------------------------------------------------
    // Selection: ALU wins; otherwise drain the FIFO head.
    // ---------------------------------------------------------------
    logic              sel_valid;
    wb_entry_t         sel;
    logic              sel_writes;

    assign q_pop      = !alu_valid && !q_empty;
    assign sel_valid  = alu_valid || !q_empty;
    assign sel_writes = sel_valid && (sel.addr != '0);

    // Chooses the entry retired on the coming edge.
    always_comb begin
        sel = '0;
        if (alu_valid) begin
            sel.addr = alu_addr;
            sel.data = alu_data;
        end else begin
            sel = q_head;
        end
    end

    // Registered write port; an entry for r0 is consumed without writing,
    // and idle cycles hold the last address and data.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rf_write <= 1'b0;
            rf_addr  <= '0;
            rf_data  <= '0;
        end else begin
            rf_write <= sel_writes;
            if (sel_writes) begin
                rf_addr <= sel.addr;
                rf_data <= sel.data;
            end
        end
    end

    // ---------------------------------------------------------------
    // Busy scoreboard: a reservation beats a same-edge retirement.
    // ---------------------------------------------------------------
    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_set;
    logic [NUM_REGS-1:0] busy_clr;
    logic [NUM_REGS-1:0] busy_next;

    // Next scoreboard value; bit 0 is never busy.
    always_comb begin
        busy_set  = rsv_valid ? reg_onehot(rsv_addr) : '0;
        busy_clr  = sel_valid ? reg_onehot(sel.addr) : '0;
        busy_next = (busy_q & ~busy_clr) | busy_set;
        busy_next[0] = 1'b0;
    end

    // Scoreboard register; reset drops all reservations.
    always_ff @(posedge clk) begin
        if (!reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_next;
        end
    end

    assign busy = busy_q;

`ifdef REGFILE_WB_BYPASS_EN
    // Forward the in-flight write to same-cycle readers of its register.
    always_comb begin
        byp_s_hit  = rf_write && (byp_s_addr == rf_addr) && (byp_s_addr != '0);
        byp_t_hit  = rf_write && (byp_t_addr == rf_addr) && (byp_t_addr != '0);
        byp_s_data = byp_s_hit ? rf_data : '0;
        byp_t_data = byp_t_hit ? rf_data : '0;
    end
`endif

endmodule

// File: tb/tb_regfile_writeback.sv
// Bench for regfile_writeback: directed scenarios plus randomized traffic,
// checked against a queue-level model of the write-back rules.
module tb_regfile_writeback;

    import regfile_wb_pkg::*;

    localparam int QDEPTH = 4;
    localparam int EW     = ADDR_W + DATA_W;

    logic                 clk = 1'b0;
    logic                 reset = 1'b0;
    logic                 alu_valid = 1'b0;
    logic [ADDR_W-1:0]    alu_addr = '0;
    logic [DATA_W-1:0]    alu_data = '0;
    logic                 ld_valid = 1'b0;
    logic                 ld_ready;
    logic [ADDR_W-1:0]    ld_addr = '0;
    logic [DATA_W-1:0]    ld_data = '0;
    logic                 md_valid = 1'b0;
    logic                 md_ready;
    logic [ADDR_W-1:0]    md_addr = '0;
    logic [DATA_W-1:0]    md_data = '0;
    logic                 rsv_valid = 1'b0;
    logic [ADDR_W-1:0]    rsv_addr = '0;
    logic                 rf_write;
    logic [ADDR_W-1:0]    rf_addr;
    logic [DATA_W-1:0]    rf_data;
    logic [31:0]          busy;
    logic [$clog2(QDEPTH):0] q_count;
`ifdef REGFILE_WB_BYPASS_EN
    logic [ADDR_W-1:0]    byp_s_addr = '0;
    logic [ADDR_W-1:0]    byp_t_addr = '0;
    logic                 byp_s_hit;
    logic                 byp_t_hit;
    logic [DATA_W-1:0]    byp_s_data;
    logic [DATA_W-1:0]    byp_t_data;
`endif

    regfile_writeback #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .QDEPTH (QDEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .alu_valid (alu_valid),
        .alu_addr  (alu_addr),
        .alu_data  (alu_data),
        .ld_valid  (ld_valid),
        .ld_ready  (ld_ready),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data),
        .md_valid  (md_valid),
        .md_ready  (md_ready),
        .md_addr   (md_addr),
        .md_data   (md_data),
        .rsv_valid (rsv_valid),
        .rsv_addr  (rsv_addr),
        .rf_write  (rf_write),
        .rf_addr   (rf_addr),
        .rf_data   (rf_data),
        .busy      (busy),
        .q_count   (q_count)
`ifdef REGFILE_WB_BYPASS_EN
        ,
        .byp_s_addr (byp_s_addr),
        .byp_t_addr (byp_t_addr),
        .byp_s_hit  (byp_s_hit),
        .byp_t_hit  (byp_t_hit),
        .byp_s_data (byp_s_data),
        .byp_t_data (byp_t_data)
`endif
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    int                n_tests = 0;
    int                n_fail  = 0;
    logic [EW-1:0]     exp_q[$];      // expected register-file writes, in order
    logic [EW-1:0]     mq[$];         // model of queued load/mul-div results
    logic [31:0]       mbusy = '0;    // model scoreboard
    logic              m_wr = 1'b0;   // model: write currently on the port
    logic [ADDR_W-1:0] m_addr = '0;
    logic [DATA_W-1:0] m_data = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        check("rf_write", 64'(rf_write), 64'(m_wr));
        if (rf_write) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", 64'(rf_write), 64'd0);
            end else begin
                check("rf_entry", 64'({rf_addr, rf_data}), 64'(exp_q.pop_front()));
            end
        end
`ifdef REGFILE_WB_BYPASS_EN
        begin
            logic s_hit;
            logic t_hit;
            s_hit = m_wr && (byp_s_addr == m_addr) && (byp_s_addr != '0);
            t_hit = m_wr && (byp_t_addr == m_addr) && (byp_t_addr != '0);
            check("byp_s_hit", 64'(byp_s_hit), 64'(s_hit));
            check("byp_t_hit", 64'(byp_t_hit), 64'(t_hit));
            check("byp_s_data", 64'(byp_s_data), s_hit ? 64'(m_data) : 64'd0);
            check("byp_t_data", 64'(byp_t_data), t_hit ? 64'(m_data) : 64'd0);
        end
`endif
    end

    // ---------------- driver tasks ----------------
    // One clock of stimulus; also advances the reference model for that edge.
    task automatic cycle(input logic av, input logic [ADDR_W-1:0] aa, input logic [DATA_W-1:0] ad,
                         input logic lv, input logic [ADDR_W-1:0] la, input logic [DATA_W-1:0] ldd,
                         input logic mv, input logic [ADDR_W-1:0] ma, input logic [DATA_W-1:0] mdd,
                         input logic rv, input logic [ADDR_W-1:0] ra);
        int            sz;
        logic          exp_ldr;
        logic          exp_mdr;
        logic [EW-1:0] sel;
        logic          have_sel;
        @(negedge clk);
        #1;
        check("q_count", 64'(q_count), 64'(mq.size()));
        check("busy", 64'(busy), 64'(mbusy));
        alu_valid = av; alu_addr = aa; alu_data = ad;
        ld_valid  = lv; ld_addr  = la; ld_data  = ldd;
        md_valid  = mv; md_addr  = ma; md_data  = mdd;
        rsv_valid = rv; rsv_addr = ra;
        #1;
        sz      = mq.size();
        exp_ldr = (sz < QDEPTH);
        exp_mdr = exp_ldr && !lv;
        check("ld_ready", 64'(ld_ready), 64'(exp_ldr));
        check("md_ready", 64'(md_ready), 64'(exp_mdr));
        // retire: ALU first, else oldest queued result
        have_sel = 1'b0;
        sel      = '0;
        if (av) begin
            sel = {aa, ad};
            have_sel = 1'b1;
        end else if (sz > 0) begin
            sel = mq.pop_front();
            have_sel = 1'b1;
        end
        // accept: load before mul/div, only with room before this edge
        if (lv && exp_ldr) mq.push_back({la, ldd});
        else if (mv && exp_mdr) mq.push_back({ma, mdd});
        m_wr = 1'b0;
        if (have_sel) begin
            mbusy[sel[EW-1:DATA_W]] = 1'b0;
            if (sel[EW-1:DATA_W] != '0) begin
                exp_q.push_back(sel);
                m_wr   = 1'b1;
                m_addr = sel[EW-1:DATA_W];
                m_data = sel[DATA_W-1:0];
            end
        end
        if (rv) mbusy[ra] = 1'b1;
        mbusy[0] = 1'b0;
`ifdef REGFILE_WB_BYPASS_EN
        byp_s_addr = ($urandom_range(0, 1) == 1) ? m_addr : ADDR_W'($urandom_range(0, 31));
        byp_t_addr = ($urandom_range(0, 3) == 0) ? '0 : ADDR_W'($urandom_range(0, 31));
`endif
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic reset_dut();
        @(negedge clk);
        #1;
        reset = 1'b0;
        alu_valid = 1'b0; ld_valid = 1'b0; md_valid = 1'b0; rsv_valid = 1'b0;
        exp_q.delete();
        mq.delete();
        mbusy = '0;
        m_wr  = 1'b0;
        m_addr = '0;
        m_data = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check("rst_rf_write", 64'(rf_write), 64'd0);
        check("rst_rf_addr", 64'(rf_addr), 64'd0);
        check("rst_rf_data", 64'(rf_data), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_q_count", 64'(q_count), 64'd0);
        check("rst_ld_ready", 64'(ld_ready), 64'd1);
        check("rst_md_ready", 64'(md_ready), 64'd1);
        reset = 1'b1;
    endtask

    task automatic random_run(input int n);
        for (int i = 0; i < n; i++) begin
            cycle(($urandom_range(0, 9) < 4), ADDR_W'($urandom_range(0, 31)), $urandom,
                  ($urandom_range(0, 1) == 1), ADDR_W'($urandom_range(0, 31)), $urandom,
                  ($urandom_range(0, 1) == 1), ADDR_W'($urandom_range(0, 31)), $urandom,
                  ($urandom_range(0, 9) < 3), ADDR_W'($urandom_range(0, 31)));
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset_dut();

        // ALU write to r5 after reserving it
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5);
        cycle(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(2);

        // contention: load then mul/div queued behind three ALU writes
        cycle(1, 1, 32'hA1, 1, 3, 32'h11, 1, 4, 32'h22, 0, 0);
        cycle(1, 2, 32'hA2, 0, 0, 0, 1, 4, 32'h22, 0, 0);
        cycle(1, 6, 32'hA3, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(4);

        // fill the FIFO under ALU pressure, then a fifth load must wait
        for (int i = 0; i < 4; i++) begin
            cycle(1, ADDR_W'(10 + i), 32'(i), 1, ADDR_W'(16 + i), 32'(100 + i), 0, 0, 0, 0, 0);
        end
        cycle(1, 14, 32'hB0, 1, 20, 32'h99, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 1, 20, 32'h99, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 1, 20, 32'h99, 0, 0, 0, 0, 0);
        idle(6);

        // load to r0 is consumed silently
        cycle(0, 0, 0, 1, 0, 32'h77, 0, 0, 0, 0, 0);
        idle(3);

        // reservation racing a write to the same register keeps it busy
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 7);
        cycle(1, 7, 32'h70, 0, 0, 0, 0, 0, 0, 1, 7);
        idle(1);
        @(negedge clk);
        #1;
        check("busy7_race", 64'(busy[7]), 64'd1);

        // randomized traffic, a mid-run reset, then more traffic
        random_run(1500);
        reset_dut();
        random_run(600);
        idle(12);
        @(negedge clk);
        #1;
        check("exp_q_drained", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
